acc_drain_collector: RTL

- Sits directly downstream of the PE grid's bottom edge.
- Drives the grid's FLUSH control and captures the COLS accumulators leaving the bottom row each flush cycle. Emits them as one packed result row per valid/ready handshake.
- One drain moves all ROWS rows out of the array. The order is bottom row first.

---
 rtl/sa_pkg.sv | 22 ++
 rtl/acc_lane_post.sv | 35 +++
 rtl/acc_drain_collector.sv | 104 ++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared systolic-array definitions: default grid geometry, drain FSM states
// and the lane-slice helper used to address packed accumulator rows.
package sa_pkg;

  localparam int ROWS_DEF        = 4;
  localparam int COLS_DEF        = 4;
  localparam int OPND_BWIDTH_DEF = 8;
  localparam int ACC_BWIDTH_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_LAST,
    ST_DONE
  } drain_state_e;

  // LSB position of lane 'lane' inside a packed row of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/acc_lane_post.sv
// One result lane: captures a bottom-row accumulator on a flush cycle.
// With DRAIN_RELU_EN defined, negative values are clamped to zero at capture.
module acc_lane_post #(
  parameter int ACC_BWIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cap_i,
  input  logic signed [ACC_BWIDTH-1:0] acc_i,
  output logic signed [ACC_BWIDTH-1:0] res_o
);

`ifdef DRAIN_RELU_EN
  function automatic logic signed [ACC_BWIDTH-1:0] post(input logic signed [ACC_BWIDTH-1:0] v);
    return v[ACC_BWIDTH-1] ? '0 : v;
  endfunction
`else
  function automatic logic signed [ACC_BWIDTH-1:0] post(input logic signed [ACC_BWIDTH-1:0] v);
    return v;
  endfunction
`endif

  logic signed [ACC_BWIDTH-1:0] res_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q <= '0;
    end else if (cap_i) begin
      res_q <= post(acc_i);
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/acc_drain_collector.sv
// Drains the PE grid bottom row first, one result row per valid/ready handshake.
// Optional lane ReLU at capture is enabled by defining DRAIN_RELU_EN.
module acc_drain_collector
  import sa_pkg::*;
#(
  parameter int ROWS       = ROWS_DEF,
  parameter int COLS       = COLS_DEF,
  parameter int ACC_BWIDTH = ACC_BWIDTH_DEF,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic [COLS*ACC_BWIDTH-1:0] ACC_col_in,
  output logic                       FLUSH,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       RES_valid,
  input  logic                       RES_ready,
  output logic [COLS*ACC_BWIDTH-1:0] RES_data,
  output logic [RW-1:0]              RES_row
);

  drain_state_e    state_q, state_d;
  logic [RW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic            vld_q, vld_d;
  logic            flush;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      vld_q   <= vld_d;
    end
  end

  // The grid only shifts when the output register is empty or being emptied,
  // so backpressure freezes the array instead of dropping a row.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    vld_d   = vld_q;
    flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_DRAIN;
          cnt_d   = RW'(ROWS - 1);
        end
      end
      ST_DRAIN: begin
        flush = ~vld_q | RES_ready;
        if (flush) begin
          vld_d = 1'b1;
          row_d = cnt_q;
          if (cnt_q == '0) begin
            state_d = ST_LAST;
          end else begin
            cnt_d = cnt_q - RW'(1);
          end
        end
      end
      ST_LAST: begin
        if (vld_q && RES_ready) begin
          vld_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    acc_lane_post #(
      .ACC_BWIDTH(ACC_BWIDTH)
    ) u_lane (
      .clk_i (CLK),
      .rst_i (RST),
      .cap_i (flush),
      .acc_i (ACC_col_in[lane_lsb(c, ACC_BWIDTH) +: ACC_BWIDTH]),
      .res_o (RES_data[lane_lsb(c, ACC_BWIDTH) +: ACC_BWIDTH])
    );
  end

  assign FLUSH     = flush;
  assign BUSY      = (state_q == ST_DRAIN) || (state_q == ST_LAST);
  assign DONE      = (state_q == ST_DONE);
  assign RES_valid = vld_q;
  assign RES_row   = row_q;

endmodule
